// File: rtl/chunk_serializer.sv
// Splits a DATA_BITS word into NUM_CHUNKS chunks and streams them out over a
// valid/ready handshake, LSB-chunk-first or MSB-chunk-first per word.
module chunk_serializer #(
    parameter int CHUNK_BITS = 4,
    parameter int NUM_CHUNKS = 8,
    localparam int DATA_BITS = CHUNK_BITS * NUM_CHUNKS,
    localparam int IDX_BITS  = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_BITS-1:0]  in_data,
    input  logic                  in_msb_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CHUNK_BITS-1:0] out_chunk,
    output logic                  out_last,
    output logic                  busy
);

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CHUNKS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_reg;
    logic [DATA_BITS-1:0]  word_reg;
    logic                  msb_reg;
    logic [IDX_BITS-1:0]   cnt_reg;
    logic [CHUNK_BITS-1:0] chunk_reg;
    logic                  last_reg;

    logic                  transfer;
    logic                  load;
    logic [IDX_BITS-1:0]   step_cnt;
    logic [IDX_BITS-1:0]   step_idx;
    logic [IDX_BITS-1:0]   load_idx;

    logic [CHUNK_BITS-1:0] in_chunks   [NUM_CHUNKS];
    logic [CHUNK_BITS-1:0] held_chunks [NUM_CHUNKS];

    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunks
            assign in_chunks[gi]   = in_data[gi*CHUNK_BITS +: CHUNK_BITS];
            assign held_chunks[gi] = word_reg[gi*CHUNK_BITS +: CHUNK_BITS];
        end
    endgenerate

    assign out_valid = (state_reg == SHIFT);
    assign busy      = (state_reg == SHIFT);
    assign out_chunk = chunk_reg;
    assign out_last  = last_reg && out_valid;
    assign transfer  = out_valid && out_ready;
    // A new word may enter while the final chunk of the current one leaves.
    assign in_ready  = (state_reg == IDLE) || (transfer && last_reg);
    assign load      = in_valid && in_ready;

    always_comb begin
        step_cnt = cnt_reg + 1'b1;
        step_idx = msb_reg ? (LAST_IDX - step_cnt) : step_cnt;
        load_idx = in_msb_first ? LAST_IDX : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            word_reg  <= '0;
            msb_reg   <= 1'b0;
            cnt_reg   <= '0;
            chunk_reg <= '0;
            last_reg  <= 1'b0;
        end else if (load) begin
            state_reg <= SHIFT;
            word_reg  <= in_data;
            msb_reg   <= in_msb_first;
            cnt_reg   <= '0;
            chunk_reg <= in_chunks[load_idx];
            last_reg  <= (LAST_IDX == '0);
        end else if (transfer && last_reg) begin
            // Final chunk gone and nothing new: chunk/last hold their values.
            state_reg <= IDLE;
        end else if (transfer) begin
            cnt_reg   <= step_cnt;
            chunk_reg <= held_chunks[step_idx];
            last_reg  <= (step_cnt == LAST_IDX);
        end
    end

endmodule

// File: doc/chunk_serializer.md
CHUNK_SERIALIZER -- requirements
Module: chunk_serializer

Interface
REQ-001 Parameter CHUNK_BITS, default 4: width of one output chunk.
REQ-002 Parameter NUM_CHUNKS, default 8: chunks per input word; legal range >= 1.
REQ-003 Derived DATA_BITS = CHUNK_BITS*NUM_CHUNKS; IDX_BITS = max(1, $clog2(NUM_CHUNKS)).
REQ-004 clk  input  1  clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  in_data and in_msb_first valid.
REQ-007 in_ready  output  1  block accepts a word this cycle.
REQ-008 in_data  input  DATA_BITS  word to serialise; chunk i = in_data[i*CHUNK_BITS +: CHUNK_BITS].
REQ-009 in_msb_first  input  1  order for this word: 0 = chunk 0 first, 1 = chunk NUM_CHUNKS-1 first.
REQ-010 out_valid  output  1  out_chunk holds a valid chunk.
REQ-011 out_ready  input  1  consumer takes out_chunk this cycle.
REQ-012 out_chunk  output  CHUNK_BITS  current chunk.
REQ-013 out_last  output  1  current chunk is the final chunk of its word.
REQ-014 busy  output  1  a word is held (state SHIFT).

Function
REQ-015 Two states: IDLE (no word held), SHIFT (word held, chunks pending).
REQ-016 Load = in_valid && in_ready; on load, capture in_data and in_msb_first, clear sent-count to 0, enter SHIFT.
REQ-017 in_ready = (state == IDLE) || (out_valid && out_ready && out_last); combinational, no dependency on in_valid.
REQ-018 Transfer = out_valid && out_ready; each transfer increments sent-count by 1.
REQ-019 out_valid = 1 exactly in SHIFT; out_chunk and out_last registered, valid from the cycle after load (latency 1).
REQ-020 out_chunk = chunk[k] where k = sent-count (LSB-first) or NUM_CHUNKS-1-sent-count (MSB-first).
REQ-021 out_last = 1 when sent-count == NUM_CHUNKS-1.
REQ-022 While out_valid && !out_ready, out_chunk, out_last and the held word stay unchanged.
REQ-023 Transfer with out_last and no load in the same cycle: SHIFT -> IDLE, out_valid 0 next cycle.
REQ-024 Transfer with out_last and simultaneous load: stay SHIFT, next cycle presents chunk of the new word; no idle bubble.
REQ-025 in_valid in SHIFT without final transfer: ignored, no capture; source holds its word.
REQ-026 Sent-count never exceeds NUM_CHUNKS-1; no wrap into a stale word.
REQ-027 NUM_CHUNKS == 1: every chunk has out_last = 1; in_msb_first has no effect.
REQ-028 In IDLE out_chunk, out_last keep last values but qualify nothing; out_last forced 0 when out_valid is 0.

Reset
REQ-029 reset asserted: state IDLE, sent-count 0, out_valid 0, out_last 0, out_chunk 0, busy 0, held word 0, immediately and without clk.
REQ-030 in_ready = 1 while in IDLE, including during reset.
REQ-031 Reset mid-word discards remaining chunks; the first transfer after release comes from a newly loaded word.

Verification
REQ-032 Defaults, load 0xABCD1234 msb_first=0, out_ready=1: out_chunk 4,3,2,1,D,C,B,A on 8 consecutive cycles starting 1 cycle after load; out_last only on A; out_valid 0 next cycle.
REQ-033 Same word msb_first=1: sequence A,B,C,D,1,2,3,4; out_last only on 4.
REQ-034 out_ready toggled 1,0,0,1,... during a word: no chunk dropped or duplicated; out_chunk stable across stall cycles.
REQ-035 in_valid held high with words 0x11111111 then 0x22222222, out_ready=1: 16 chunks on 16 consecutive cycles, in_ready pulses only with the final chunk of word 1.
REQ-036 Assert reset asynchronously after 3 chunks: out_valid, out_last, busy drop to 0 before the next clk edge; a new word loads cleanly after release.
REQ-037 CHUNK_BITS=8, NUM_CHUNKS=1, load 0x5A: one transfer, out_chunk 0x5A, out_last 1, back-to-back loads every cycle.
